// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared phase encoding and duty-range helper for the RGB PWM path
package pwm_pkg;

    typedef enum logic [2:0] {
        PH_RG_UP = 3'd0,
        PH_GR_DN = 3'd1,
        PH_GB_UP = 3'd2,
        PH_BG_DN = 3'd3,
        PH_BR_UP = 3'd4,
        PH_BR_DN = 3'd5
    } phase_e;

    // Full-on duty for an r-bit PWM stage; duty words are r+1 bits wide.
    function automatic int max_level(input int r);
        return 1 << r;
    endfunction

endpackage

// File: rtl/step_tick_gen.sv
// rtl/step_tick_gen.sv - enabled prescaler producing a step tick every step_div_i+1 cycles
module step_tick_gen #(
    parameter int DIV_BITS = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                enable_i,
    input  logic                restart_i,
    input  logic [DIV_BITS-1:0] step_div_i,
    output logic                tick_o
);

    logic [DIV_BITS-1:0] cnt_q, cnt_d;

    // >= rather than == so a shrinking divider ticks immediately instead of wrapping.
    assign tick_o = enable_i && (cnt_q >= step_div_i);

    always_comb begin
        cnt_d = cnt_q;
        if (restart_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = tick_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rgb_hue_sequencer.sv
// rtl/rgb_hue_sequencer.sv - six-phase colour wheel with brightness scaling feeding the RGB PWM stage
module rgb_hue_sequencer
    import pwm_pkg::*;
#(
    parameter int R        = 8,
    parameter int DIV_BITS = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                enable_i,
    input  logic                restart_i,
    input  logic [DIV_BITS-1:0] step_div_i,
    input  logic [R-1:0]        bright_i,
    output logic [R:0]          r_duty,
    output logic [R:0]          g_duty,
    output logic [R:0]          b_duty,
    output logic [2:0]          phase_o,
    output logic                wrap_o
);

    localparam logic [R:0] MAX_V = (R+1)'(max_level(R));
    localparam logic [R:0] LAST  = MAX_V - 1'b1;

    logic       tick;
    phase_e     phase_q, phase_d;
    logic [R:0] lvl_q, lvl_d;
    logic       wrap_q, wrap_d;
    logic [R:0] r_q, g_q, b_q, r_d, g_d, b_d;
    logic [R:0] raw_r, raw_g, raw_b, inv;

    step_tick_gen #(.DIV_BITS(DIV_BITS)) u_tick (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .enable_i   (enable_i),
        .restart_i  (restart_i),
        .step_div_i (step_div_i),
        .tick_o     (tick)
    );

    // (raw * (bright+1)) >> R never exceeds MAX because bright+1 <= 2^R.
    function automatic logic [R:0] scale(input logic [R:0] raw, input logic [R-1:0] br);
        logic [2*R:0] p;
        p = (2*R+1)'(raw) * (2*R+1)'({1'b0, br} + (R+1)'(1));
        return (R+1)'(p >> R);
    endfunction

    always_comb begin
        phase_d = phase_q;
        lvl_d   = lvl_q;
        wrap_d  = 1'b0;
        if (restart_i) begin
            phase_d = PH_RG_UP;
            lvl_d   = '0;
        end else if (tick) begin
            if (lvl_q == LAST) begin
                lvl_d   = '0;
                wrap_d  = (phase_q == PH_BR_DN);
                phase_d = (phase_q == PH_BR_DN) ? PH_RG_UP : phase_e'(3'(phase_q + 3'd1));
            end else begin
                lvl_d = lvl_q + 1'b1;
            end
        end
    end

    always_comb begin
        inv   = MAX_V - lvl_q;
        raw_r = '0;
        raw_g = '0;
        raw_b = '0;
        case (phase_q)
            PH_RG_UP: begin raw_r = MAX_V; raw_g = lvl_q; end
            PH_GR_DN: begin raw_r = inv;   raw_g = MAX_V; end
            PH_GB_UP: begin raw_g = MAX_V; raw_b = lvl_q; end
            PH_BG_DN: begin raw_g = inv;   raw_b = MAX_V; end
            PH_BR_UP: begin raw_r = lvl_q; raw_b = MAX_V; end
            PH_BR_DN: begin raw_r = MAX_V; raw_b = inv;   end
            default:  begin raw_r = '0;    raw_g = '0;    end
        endcase
        r_d = scale(raw_r, bright_i);
        g_d = scale(raw_g, bright_i);
        b_d = scale(raw_b, bright_i);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            phase_q <= PH_RG_UP;
            lvl_q   <= '0;
            wrap_q  <= 1'b0;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
        end else begin
            phase_q <= phase_d;
            lvl_q   <= lvl_d;
            wrap_q  <= wrap_d;
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
        end
    end

    assign r_duty  = r_q;
    assign g_duty  = g_q;
    assign b_duty  = b_q;
    assign phase_o = phase_q;
    assign wrap_o  = wrap_q;

endmodule

// File: tb/tb_rgb_hue_sequencer.sv
// tb/tb_rgb_hue_sequencer.sv - self-checking bench for rgb_hue_sequencer
module tb_rgb_hue_sequencer;

    localparam int R  = 4;
    localparam int DB = 8;
    localparam int M  = 16;
    localparam int REV = 6 * M;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          rs = 1'b0;
    logic [DB-1:0] div = '0;
    logic [R-1:0]  br = '0;
    logic [R:0]    r_d, g_d, b_d;
    logic [2:0]    ph;
    logic          wr;

    int errs = 0;
    int checks = 0;
    int m_cnt = 0;
    int m_pos = 0;

    typedef struct {
        bit en; bit rs; int br;
        int er; int eg; int eb; int eph; int ewr;
    } vec_t;
    vec_t vecs[7];

    int tr[REV], tg[REV], tbl[REV];
    int wraps;
    int gseq[4];
    int exp_g[4];

    rgb_hue_sequencer #(.R(R), .DIV_BITS(DB)) dut (
        .clk_i      (clk),
        .rst_i      (rst_n),
        .enable_i   (en),
        .restart_i  (rs),
        .step_div_i (div),
        .bright_i   (br),
        .r_duty     (r_d),
        .g_duty     (g_d),
        .b_duty     (b_d),
        .phase_o    (ph),
        .wrap_o     (wr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Colour at wheel position pos (0..6M-1): phase = pos/M, level = pos%M.
    function automatic int raw_ch(input int pos, input int ch);
        int p, l;
        int c[3];
        p = pos / M;
        l = pos % M;
        case (p)
            0: c = '{M, l, 0};
            1: c = '{M - l, M, 0};
            2: c = '{0, M, l};
            3: c = '{0, M - l, M};
            4: c = '{l, 0, M};
            default: c = '{M, 0, M - l};
        endcase
        return c[ch];
    endfunction

    function automatic int scl(input int v, input int b);
        return (v * (b + 1)) / M;
    endfunction

    task automatic step(input string tag);
        int er, eg, eb, ew;
        er = scl(raw_ch(m_pos, 0), int'(br));
        eg = scl(raw_ch(m_pos, 1), int'(br));
        eb = scl(raw_ch(m_pos, 2), int'(br));
        ew = 0;
        if (rs) begin
            m_cnt = 0;
            m_pos = 0;
        end else if (en) begin
            if (m_cnt >= int'(div)) begin
                m_cnt = 0;
                if (m_pos == REV - 1) ew = 1;
                m_pos = (m_pos + 1) % REV;
            end else begin
                m_cnt++;
            end
        end
        @(posedge clk);
        #1;
        chk($sformatf("%s.r", tag), r_d, er);
        chk($sformatf("%s.g", tag), g_d, eg);
        chk($sformatf("%s.b", tag), b_d, eb);
        chk($sformatf("%s.phase", tag), ph, m_pos / M);
        chk($sformatf("%s.wrap", tag), wr, ew);
    endtask

    task automatic chk_zero(input string tag);
        chk($sformatf("%s.r", tag), r_d, 0);
        chk($sformatf("%s.g", tag), g_d, 0);
        chk($sformatf("%s.b", tag), b_d, 0);
        chk($sformatf("%s.phase", tag), ph, 0);
        chk($sformatf("%s.wrap", tag), wr, 0);
    endtask

    task automatic restart_wheel();
        rs = 1'b1;
        step("restart");
        rs = 1'b0;
    endtask

    initial begin
        vecs[0] = '{0, 0, 15, 16, 0, 0, 0, 0};
        vecs[1] = '{1, 0, 15, 16, 0, 0, 0, 0};
        vecs[2] = '{1, 0, 15, 16, 1, 0, 0, 0};
        vecs[3] = '{1, 0,  7,  8, 1, 0, 0, 0};
        vecs[4] = '{0, 0,  0,  1, 0, 0, 0, 0};
        vecs[5] = '{0, 1, 15, 16, 3, 0, 0, 0};
        vecs[6] = '{1, 0, 15, 16, 0, 0, 0, 0};
        exp_g = '{1, 2, 2, 3};

        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            en = vecs[i].en;
            rs = vecs[i].rs;
            br = R'(vecs[i].br);
            step($sformatf("vec%0d", i));
            chk($sformatf("tab%0d.r", i), r_d, vecs[i].er);
            chk($sformatf("tab%0d.g", i), g_d, vecs[i].eg);
            chk($sformatf("tab%0d.b", i), b_d, vecs[i].eb);
            chk($sformatf("tab%0d.phase", i), ph, vecs[i].eph);
            chk($sformatf("tab%0d.wrap", i), wr, vecs[i].ewr);
        end
        rs = 1'b0;

        // Full revolution at one tick per cycle.
        br = 4'd15;
        div = '0;
        restart_wheel();
        en = 1'b1;
        wraps = 0;
        for (int k = 0; k < REV; k++) begin
            step("rev");
            tr[k] = int'(r_d);
            tg[k] = int'(g_d);
            tbl[k] = int'(b_d);
            if (wr) wraps++;
        end
        chk("rev.wrap_count", wraps, 1);
        chk("rev.p0_end_r", tr[15], 16);
        chk("rev.p0_end_g", tg[15], 15);
        chk("rev.p1_start_r", tr[16], 16);
        chk("rev.p1_start_g", tg[16], 16);
        for (int k = 1; k < REV; k++) begin
            chk($sformatf("rev.distinct%0d", k),
                (tr[k] == tr[k-1] && tg[k] == tg[k-1] && tbl[k] == tbl[k-1]), 0);
        end

        // Step rate, then shrink the divider while cnt=3.
        div = 8'd3;
        restart_wheel();
        for (int k = 0; k < 7; k++) step("div3");
        div = 8'd1;
        for (int k = 0; k < 4; k++) begin
            step("div1");
            gseq[k] = int'(g_d);
        end
        for (int k = 0; k < 4; k++) chk($sformatf("div_drop.g%0d", k), gseq[k], exp_g[k]);

        // Freeze at phase 2, level 7.
        div = '0;
        restart_wheel();
        for (int k = 0; k < 39; k++) step("to_p2");
        en = 1'b0;
        for (int k = 0; k < 50; k++) begin
            step("freeze");
            chk("freeze.r", r_d, 0);
            chk("freeze.g", g_d, 16);
            chk("freeze.b", b_d, 7);
            chk("freeze.phase", ph, 2);
        end

        // Restart coincident with the wrapping tick.
        en = 1'b1;
        restart_wheel();
        for (int k = 0; k < REV - 1; k++) step("to_95");
        rs = 1'b1;
        step("rs_tick");
        chk("rs_tick.wrap", wr, 0);
        chk("rs_tick.phase", ph, 0);
        rs = 1'b0;
        step("after_rs");
        chk("after_rs.g", g_d, 0);

        // Brightness at P0, level 8.
        restart_wheel();
        for (int k = 0; k < 8; k++) step("to_l8");
        en = 1'b0;
        br = 4'd7;
        step("bright7");
        chk("bright7.r", r_d, 8);
        chk("bright7.g", g_d, 4);
        br = 4'd0;
        step("bright0");
        chk("bright0.r", r_d, 1);
        chk("bright0.g", g_d, 0);

        // Randomised run against the model.
        for (int k = 0; k < 400; k++) begin
            en  = ($urandom_range(0, 9) < 7);
            rs  = ($urandom_range(0, 29) == 0);
            div = DB'($urandom_range(0, 3));
            br  = R'($urandom);
            step("rand");
        end
        rs = 1'b0;

        // Asynchronous reset mid-run.
        en = 1'b1;
        br = 4'd15;
        div = '0;
        for (int k = 0; k < 20; k++) step("pre_rst");
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("async_rst");
        m_cnt = 0;
        m_pos = 0;
        @(posedge clk);
        #1;
        chk_zero("held_rst");
        rst_n = 1'b1;
        step("post_rst");
        chk("post_rst.r", r_d, 16);
        chk("post_rst.g", g_d, 0);
        chk("post_rst.b", b_d, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/rgb_hue_sequencer.md
Name: rgb_hue_sequencer

Overview:
- Generates the three duty words `r_duty`, `g_duty` and `b_duty` that feed the RGB PWM stage. It sits directly upstream of the three PWM controllers.
- Walks a six-phase colour wheel at a programmable step rate and applies a global brightness scale.
- All outputs are registered, so they can drive the `duty_i` inputs of the PWM controllers directly.

Parameters:
- R, 8: duty resolution. Full-on duty is MAX = 2^R; duty outputs are R+1 bits, matching the PWM stage.
- DIV_BITS, 16: width of the step-rate divider.

Ports:
- clk_i  input  1  system clock; all logic on the rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- enable_i  input  1  1 = wheel advances; 0 = freeze hue (brightness still applies).
- restart_i  input  1  synchronous restart of the wheel to phase 0, level 0.
- step_div_i  input  DIV_BITS  a tick occurs every step_div_i+1 enabled cycles.
- bright_i  input  R  brightness; 2^R-1 = full scale.
- r_duty  output  R+1  red duty, 0..MAX.
- g_duty  output  R+1  green duty, 0..MAX.
- b_duty  output  R+1  blue duty, 0..MAX.
- phase_o  output  3  current wheel phase, 0..5.
- wrap_o  output  1  one-cycle pulse when the phase wraps from 5 to 0.

Behaviour:
- Reset (rst_i=0, asynchronous): prescaler=0, phase=0, lvl=0, all duties=0, phase_o=0, wrap_o=0.
  - First update after release: red=(MAX*(bright_i+1))>>R, green=0, blue=0.
- Prescaler:
  - Counts only while enable_i=1.
  - tick=1 when cnt >= step_div_i; cnt then clears to 0, otherwise cnt increments.
  - The >= compare means shrinking step_div_i mid-count yields a tick on the next enabled cycle, never a 2^DIV_BITS wait.
  - step_div_i=0 gives a tick every enabled cycle.
  - enable_i=0 holds cnt, phase and lvl.
- Level counter lvl: width R+1, range 0..MAX-1. On tick:
  - If lvl==MAX-1: lvl<=0 and the phase advances (5 wraps to 0).
  - Otherwise lvl<=lvl+1.
- Channel values per phase (raw):
  - P0: R=MAX, G=lvl, B=0
  - P1: R=MAX-lvl, G=MAX, B=0
  - P2: R=0, G=MAX, B=lvl
  - P3: R=0, G=MAX-lvl, B=MAX
  - P4: R=lvl, G=0, B=MAX
  - P5: R=MAX, G=0, B=MAX-lvl
- Wheel properties: no repeated colour at phase boundaries; one full revolution is 6*MAX ticks.
- Output scaling: duty = (raw * (bright_i+1)) >> R.
  - Product width is 2R+1 bits; the result is always <= MAX, so no saturation logic is needed.
- Latency:
  - Outputs are registered, one cycle after the state or bright_i change.
  - phase_o is registered with the state.
  - wrap_o asserts in the same cycle phase_o becomes 0 after a wrap.
- restart_i=1: cnt, lvl and phase clear to 0 on the next edge.
  - Takes priority over a coincident tick; no wrap_o is generated.
  - Operates regardless of enable_i.
- Reset mid-operation: immediate asynchronous clear to the reset state; no partial outputs.

Decomposition:
- Shared package pwm_pkg holds:
  - phase encoding constants PH_RG_UP..PH_BR_DN (3 bits, 0..5);
  - the MAX_LEVEL(R) = 2^R localparam convention, shared with the PWM controller.
- Sub-module step_tick_gen (prescaler with enable, restart and the >= compare, tick output).
- FSM, level counter and scaling stay in the top module.

Test Plan:
- Reset check, bench R=4 (MAX=16): rst_i=0 mid-run → all duties, phase_o and wrap_o are 0 immediately. After release with bright_i=15, next cycle gives r=16, g=0, b=0.
- Full revolution: R=4, step_div_i=0, enable_i=1, bright_i=15.
  - Colour sequence at phase boundaries: (16,15,0) → (16,16,0) at the P0→P1 boundary.
  - wrap_o pulses exactly once per 96 cycles.
  - No repeated RGB triple between consecutive ticks.
- Step rate: step_div_i=3 → lvl increments every 4 cycles. Drop step_div_i to 1 while cnt=3 → tick on the next cycle, then every 2 cycles.
- Enable and restart:
  - enable_i=0 at phase 2, lvl 7 → outputs frozen for 50 cycles.
  - restart_i coincident with a tick → next state phase 0, lvl 0, wrap_o stays 0.
- Brightness: P0, lvl=8, bright_i=7 → r=(16*8)>>4=8 and g=(8*8)>>4=4 one cycle after the change. bright_i=0 → r=1, g=0.
